// File: rtl/cipher_packetizer_if.sv
// Byte-stream bundle for cipher_packetizer: ciphertext input, packet output and status.
// The slave modport is the packetizer's view; master is the surrounding environment.
interface cipher_packetizer_if #(
  parameter int N     = 8,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, overflow, fifo_level
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, overflow, fifo_level
  );
endinterface

// File: rtl/cipher_packetizer.sv
// Buffers ciphertext bytes and frames them as SYNC, LEN, [SEQ], payload, XOR checksum packets.
// Define CIPHER_PKT_SEQ_EN to insert a per-packet sequence byte after the length byte.
module cipher_packetizer #(
  parameter int             N       = 8,
  parameter int             DEPTH   = 16,
  parameter int             PKT_LEN = 4,
  parameter logic [N-1:0]   SYNC    = 8'hA5
) (
  input  logic                clock,
  input  logic                rst,
  cipher_packetizer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
`ifdef CIPHER_PKT_SEQ_EN
    SEQ,
`endif
    PAY,
    CHK
  } state_e;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_q, overflow_q, avail_q;
  logic          full, push, pop, hs;

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [N-1:0]  csum_q, csum_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [LW-1:0] cnt_q, cnt_d;
`ifdef CIPHER_PKT_SEQ_EN
  logic [N-1:0]  seq_q, seq_d;
`endif

  // Full is judged on the registered level, so a same-edge pop never frees room for a push.
  assign full = (level_q == LW'(DEPTH));
  assign push = bus.in_valid && !full;
  assign hs   = valid_q && bus.out_ready;
  assign pop  = hs && (state_q == PAY);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wptr_q] <= bus.in_data;
    end
  end

  // avail_q lags level by one cycle; level only falls during PAY, so IDLE never sees a stale true.
  always_ff @(posedge clock) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      avail_q    <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q    <= level_d;
      in_ready_q <= (level_d != LW'(DEPTH));
      avail_q    <= (level_q >= LW'(PKT_LEN));
      if (bus.in_valid && full) overflow_q <= 1'b1;
    end
  end

  // Output registers are loaded with the byte of the state being entered.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
`ifdef CIPHER_PKT_SEQ_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      IDLE: begin
        if (avail_q) begin
          state_d = HDR;
          valid_d = 1'b1;
          data_d  = SYNC;
          csum_d  = '0;
        end
      end
      HDR: begin
        if (hs) begin
          state_d = LEN;
          data_d  = N'(PKT_LEN);
        end
      end
      LEN: begin
        if (hs) begin
          cnt_d = '0;
`ifdef CIPHER_PKT_SEQ_EN
          state_d = SEQ;
          data_d  = seq_q;
`else
          state_d = PAY;
          data_d  = mem_q[rptr_q];
`endif
        end
      end
`ifdef CIPHER_PKT_SEQ_EN
      SEQ: begin
        if (hs) begin
          csum_d  = csum_q ^ data_q;
          state_d = PAY;
          data_d  = mem_q[rptr_q];
        end
      end
`endif
      PAY: begin
        if (hs) begin
          csum_d = csum_q ^ data_q;
          if (cnt_q == LW'(PKT_LEN - 1)) begin
            state_d = CHK;
            data_d  = csum_d;
            last_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + LW'(1);
            data_d = mem_q[rptr_q + AW'(1)];
          end
        end
      end
      CHK: begin
        if (hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = '0;
`ifdef CIPHER_PKT_SEQ_EN
          seq_d   = seq_q + N'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      csum_q  <= '0;
      cnt_q   <= '0;
`ifdef CIPHER_PKT_SEQ_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
`ifdef CIPHER_PKT_SEQ_EN
      seq_q   <= seq_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = level_q;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_last   = last_q;
endmodule

// File: doc/cipher_packetizer.md
Name: cipher_packetizer

Overview:
- Sits directly downstream of the 8-bit encryption stage and consumes its ciphertext byte stream (data plus valid strobe).
- Buffers ciphertext bytes in a small FIFO and emits fixed-length packets on a ready/valid byte interface.
- Packet format: SYNC header, length byte, PKT_LEN payload bytes, XOR checksum.
- Absorbs downstream backpressure. The upstream stage cannot be stalled, so overflow is flagged, never hidden.

Parameters:
- N, 8, data byte width; must equal the encryption stage width.
- DEPTH, 16, FIFO depth in bytes; power of two, at least PKT_LEN.
- PKT_LEN, 4, payload bytes per packet; range 1..DEPTH.
- SYNC, 8'hA5, header byte value (N bits).

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N  ciphertext byte from the encryption stage (its dout).
- in_valid  in  1  byte strobe from the encryption stage (its v).
- in_ready  out  1  FIFO not full; informational only, upstream does not stall.
- out_data  out  N  packet byte.
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  downstream accepts a byte when out_valid && out_ready.
- out_last  out  1  high with the checksum byte (final byte of packet).
- overflow  out  1  sticky; set when a byte is dropped.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: one synchronous cycle of rst high clears all state, including mid-packet or with backpressure pending.
  - FIFO empties; fifo_level=0; in_ready=1.
  - FSM goes to IDLE.
  - out_valid=0, out_last=0, out_data=0, overflow=0.
  - Checksum accumulator cleared; sequence counter cleared.
- Push:
  - A byte is written on every edge with in_valid=1 and FIFO not full.
  - If FIFO is full, the byte is dropped and overflow is set. This holds even when a pop occurs on the same edge; no full-bypass.
- Pop: one byte is read on the handshake edge of each PAYLOAD byte only.
- fifo_level on the same edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM states: IDLE, HDR, LEN, [SEQ], PAY, CHK.
  - IDLE: out_valid=0. Go to HDR when fifo_level >= PKT_LEN.
  - HDR: out_data=SYNC.
  - LEN: out_data=PKT_LEN.
  - PAY: out_data=FIFO head. Stay for PKT_LEN handshakes (internal payload counter).
  - CHK: out_data = XOR of all payload bytes of this packet; out_last=1.
  - Each state advances only on a handshake. After the CHK handshake, return to IDLE.
- Timing:
  - The packet begins only when a full payload is already buffered, so PAY never stalls on an empty FIFO.
  - First out_valid of a packet appears on the second rising edge after the edge that pushes the PKT_LEN-th byte.
  - IDLE costs one bubble cycle between packets.
- Stability: while out_valid=1 and out_ready=0, out_data, out_last and out_valid must stay unchanged.
- All outputs are registered. No combinational path from out_ready to out_valid or out_data.
- Width rules:
  - Checksum is an N-bit XOR, starting at 0 at HDR.
  - PKT_LEN is emitted truncated to N bits.
  - FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: CIPHER_PKT_SEQ_EN.
- Defined:
  - Adds state SEQ between LEN and PAY, emitting an N-bit sequence number.
  - The number starts at 0 after reset and increments after each CHK handshake, wrapping from 2^N-1 to 0.
  - The sequence byte is XORed into the checksum.
- Undefined:
  - No SEQ state and no counter.
  - Packet is SYNC, LEN, payload, CHK only.

Test Plan:
- After reset, push 8'h11, 22, 33, 44 on consecutive cycles with out_ready=1 -> stream A5,04,11,22,33,44,44 (XOR) with out_last only on the final byte; fifo_level returns to 0.
- Same stimulus with out_ready low for 5 cycles during PAY -> out_data held at the current byte throughout; full packet delivered intact and in order.
- Push 17 bytes (00..10) back-to-back with out_ready=0 -> fifo_level=16, in_ready=0; byte 10 dropped; overflow=1 until rst.
- Push 8 bytes continuously with out_ready=1 -> two packets with checksums of bytes 1-4 and 5-8, one IDLE bubble between them, no drops.
- Assert rst for one cycle midway through PAY -> next edge: out_valid=0, fifo_level=0, overflow=0; next 4 pushes produce a fresh correct packet.
- With CIPHER_PKT_SEQ_EN defined, send 3 packets of 8'hFF -> SEQ bytes 00,01,02; checksums 00,01,02.
